// File: rtl/div_unit.sv
// Iterative restoring divider for DIV/DIVU: one shift-subtract step per cycle,
// then a sign fix-up. Results are held until the next accepted start.
module div_unit #(
    parameter int DATA_W = 32
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              sign,
    input  logic              flush,
    input  logic [DATA_W-1:0] dividend,
    input  logic [DATA_W-1:0] divisor,
    output logic              busy,
    output logic              done,
    output logic [DATA_W-1:0] q,
    output logic [DATA_W-1:0] r,
    output logic              dz
);
    localparam int               CNT_W     = $clog2(DATA_W) + 1;
    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(DATA_W - 1);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_FIX, S_DONE} state_t;

    state_t                    state_q, state_d;
    logic [CNT_W-1:0]          cnt_q, cnt_d;
    logic                      sign_q, sign_d;
    logic signed [DATA_W-1:0]  dvd_q, dvd_d;
    logic signed [DATA_W-1:0]  dvs_q, dvs_d;
    logic [DATA_W-1:0]         quo_q, quo_d;
    logic [DATA_W-1:0]         rem_q, rem_d;
    logic                      busy_q, busy_d;
    logic                      done_q, done_d;
    logic                      dz_q, dz_d;
    logic [DATA_W-1:0]         q_q, q_d;
    logic [DATA_W-1:0]         r_q, r_d;

    logic [DATA_W-1:0]         dvs_mag;
    logic [DATA_W:0]           rem_sh;
    logic [DATA_W:0]           diff;
    logic                      can_accept;

    function automatic logic [DATA_W-1:0] neg_f(input logic [DATA_W-1:0] v);
        return (~v) + DATA_W'(1);
    endfunction

    function automatic logic [DATA_W-1:0] abs_f(input logic [DATA_W-1:0] v,
                                                input logic              is_signed);
        return (is_signed && v[DATA_W-1]) ? neg_f(v) : v;
    endfunction

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        sign_d   = sign_q;
        dvd_d    = dvd_q;
        dvs_d    = dvs_q;
        quo_d    = quo_q;
        rem_d    = rem_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        dz_d     = dz_q;
        q_d      = q_q;
        r_d      = r_q;

        dvs_mag    = abs_f(dvs_q, sign_q);
        // Borrow out of the extra top bit means the trial subtraction failed.
        rem_sh     = {rem_q, quo_q[DATA_W-1]};
        diff       = rem_sh - {1'b0, dvs_mag};
        can_accept = (state_q == S_IDLE) || (state_q == S_DONE);

        if (flush) begin
            state_d = S_IDLE;
            busy_d  = 1'b0;
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start && can_accept) begin
                        state_d = S_RUN;
                        busy_d  = 1'b1;
                        cnt_d   = '0;
                        sign_d  = sign;
                        dvd_d   = dividend;
                        dvs_d   = divisor;
                        quo_d   = abs_f(dividend, sign);
                        rem_d   = '0;
                        dz_d    = 1'b0;
                    end else begin
                        state_d = S_IDLE;
                        busy_d  = 1'b0;
                    end
                end
                S_RUN: begin
                    if (diff[DATA_W]) begin
                        rem_d = rem_sh[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b0};
                    end else begin
                        rem_d = diff[DATA_W-1:0];
                        quo_d = {quo_q[DATA_W-2:0], 1'b1};
                    end
                    cnt_d = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_STEP) begin
                        state_d = S_FIX;
                    end
                end
                S_FIX: begin
                    // A zero divisor reports the raw dividend regardless of sign mode.
                    if (dvs_q == '0) begin
                        q_d  = '1;
                        r_d  = dvd_q;
                        dz_d = 1'b1;
                    end else begin
                        q_d  = (sign_q && (dvd_q[DATA_W-1] ^ dvs_q[DATA_W-1])) ? neg_f(quo_q) : quo_q;
                        r_d  = (sign_q && dvd_q[DATA_W-1]) ? neg_f(rem_q) : rem_q;
                        dz_d = 1'b0;
                    end
                    state_d = S_DONE;
                    busy_d  = 1'b0;
                    done_d  = 1'b1;
                end
                default: begin
                    state_d = S_IDLE;
                    busy_d  = 1'b0;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            sign_q  <= 1'b0;
            dvd_q   <= '0;
            dvs_q   <= '0;
            quo_q   <= '0;
            rem_q   <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            dz_q    <= 1'b0;
            q_q     <= '0;
            r_q     <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            sign_q  <= sign_d;
            dvd_q   <= dvd_d;
            dvs_q   <= dvs_d;
            quo_q   <= quo_d;
            rem_q   <= rem_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            dz_q    <= dz_d;
            q_q     <= q_d;
            r_q     <= r_d;
        end
    end

    assign busy = busy_q;
    assign done = done_q;
    assign dz   = dz_q;
    assign q    = q_q;
    assign r    = r_q;

endmodule

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 clk  input  1  rising-edge clock for all state.
REQ-002 rst_n  input  1  asynchronous active-low reset.
REQ-003 start  input  1  request from the Control decode (DIV/DIVU issue), sampled on the rising edge.
REQ-004 sign  input  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with start.
REQ-005 flush  input  1  exception/ERET cancel; aborts any operation in flight.
REQ-006 dividend  input  32  rs operand; latched when start is accepted.
REQ-007 divisor  input  32  rt operand; latched when start is accepted.
REQ-008 busy  output  1  high while an accepted operation is in progress.
REQ-009 done  output  1  single-cycle pulse: q/r valid; the CPU pulses HI_W/LO_W on this cycle.
REQ-010 q  output  32  quotient (LO value).
REQ-011 r  output  32  remainder (HI value).
REQ-012 dz  output  1  divisor was zero for the last completed operation.

Function
REQ-013 Use a registered FSM with states IDLE, RUN, FIX and DONE.
REQ-014 Accept start only in IDLE or DONE; in that cycle latch the operands, latch sign, clear dz and enter RUN.
REQ-015 Ignore start in RUN or FIX: no operand update, no restart.
REQ-016 In RUN, perform one restoring shift-subtract step per cycle on |dividend| and |divisor|, using a 6-bit counter.
REQ-017 Stay in RUN for exactly 32 cycles, then go to FIX.
REQ-018 In FIX, apply signs when sign=1: negate q if the operand signs differ; negate r if the dividend is negative.
REQ-019 FIX lasts 1 cycle, then go to DONE.
REQ-020 In DONE, hold done=1 for one cycle, then go to IDLE, unless start is accepted in that same cycle.
REQ-021 Latency: start accepted at edge N -> busy=1 on cycles N+1..N+33 -> done=1 on cycle N+34 with busy=0.
REQ-022 Hold q, r and dz stable from done until the next accepted start.
REQ-023 Leave q and r unchanged while RUN/FIX are in progress; update them only on entry to DONE.
REQ-024 Signed division truncates toward zero; the remainder takes the sign of the dividend; 2's-complement 32-bit wrap throughout.
REQ-025 Divisor = 0 uses the same latency and gives q=0xFFFFFFFF, r=dividend (raw), dz=1, for both sign settings.
REQ-026 Signed 0x80000000 / 0xFFFFFFFF gives q=0x80000000, r=0, dz=0, with no trap.
REQ-027 flush=1 in any state -> IDLE on the next edge, busy=0, no done pulse, q/r/dz unchanged.
REQ-028 flush has priority over a simultaneous start: the start is dropped.
REQ-029 If the remainder register is 33 bits, use it internally only; outputs are 32-bit.

Reset
REQ-030 rst_n=0 forces IDLE immediately, independent of clk.
REQ-031 rst_n=0 clears busy, done, q, r, dz and the counter to 0.
REQ-032 Reset during RUN/FIX aborts the operation; no done pulse follows release.
REQ-033 After release, the first start is accepted on the first rising edge with rst_n=1.

Verification
REQ-034 Unsigned 100/7, start at edge 0 -> busy cycles 1..33; done at cycle 34 with q=14, r=2, dz=0.
REQ-035 Signed cases:
- -7/2 -> q=0xFFFFFFFD, r=0xFFFFFFFF.
- 7/-2 -> q=0xFFFFFFFD, r=1.
- 0x80000000/-1 -> q=0x80000000, r=0.
REQ-036 Divide by zero:
- Unsigned 0x1234/0 -> q=0xFFFFFFFF, r=0x1234, dz=1, done at cycle 34.
- Signed 0x1234/0 -> same results.
REQ-037 Start while busy:
- 100/7 at edge 0, second start 50/5 at cycle 10 -> only q=14, r=2 at cycle 34.
- start asserted in the DONE cycle -> the new operation is accepted, back-to-back.
REQ-038 flush at cycle 20 -> busy=0 at cycle 21, no done, q/r keep their previous values.
- flush+start in the same cycle -> remains IDLE.
REQ-039 rst_n low at cycle 15 mid-RUN -> all outputs 0 asynchronously; no done after release.
- A new start after release completes normally in 34 cycles.
